addr_seq_ctrl: RTL

//  Address sequencer that owns the 6-bit address register feeding the aux_ADD incrementer.
//  On start it issues addresses 0..last_i to a downstream consumer under a valid/ready

---
 rtl/addr_seq_pkg.sv | 12 +
 rtl/addr_seq_ctrl_if.sv | 23 ++
 rtl/aux_ADD.sv | 9 +
 rtl/addr_seq_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/addr_seq_pkg.sv
// Shared types and constants for the address sequencer.
package addr_seq_pkg;

    localparam int unsigned ADDR_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addr_seq_ctrl_if.sv
// Control and address-stream signals between the sequencer and its neighbours.
interface addr_seq_ctrl_if;
    import addr_seq_pkg::*;

    logic              start_i;
    logic              abort_i;
    logic [ADDR_W-1:0] last_i;
    logic              ready_i;
    logic [ADDR_W-1:0] addr_o;
    logic              valid_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        input  start_i, abort_i, last_i, ready_i,
        output addr_o, valid_o, busy_o, done_o
    );

    modport slave (
        output start_i, abort_i, last_i, ready_i,
        input  addr_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/aux_ADD.sv
// Address incrementer; wraps silently at the top of the range.
module aux_ADD #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic [ADDR_W-1:0] a_i,
    output logic [ADDR_W-1:0] sum_o
);
    assign sum_o = a_i + ADDR_W'(1);
endmodule

// File: rtl/addr_seq_ctrl.sv
// Address sequencer: issues 0..last under valid/ready, then pulses done for one cycle.
module addr_seq_ctrl
    import addr_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    addr_seq_ctrl_if.master bus
);
    if (ADDR_W != 6) begin : g_addr_w_check
        $error("ADDR_W must be 6 to match aux_ADD");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] addr_inc;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              is_last;

    aux_ADD #(.ADDR_W(ADDR_W)) u_aux_add (
        .a_i   (addr_q),
        .sum_o (addr_inc)
    );

    assign is_last = (addr_q == last_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.start_i) state_d = S_RUN;
            // Abort wins over an accepted beat.
            S_RUN: begin
                if (bus.abort_i)                 state_d = S_IDLE;
                else if (bus.ready_i && is_last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they can be registered with no ready_i path.
    always_comb begin
        addr_d  = addr_q;
        last_d  = last_q;
        valid_d = (state_d == S_RUN);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    addr_d = '0;
                    last_d = bus.last_i;
                end
            end
            S_RUN: begin
                if (bus.abort_i)                  addr_d = '0;
                else if (bus.ready_i && !is_last) addr_d = addr_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.addr_o  = addr_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
endmodule
